// File: rtl/halfband_decim_tdm.sv
// Time-multiplexed halfband decimate-by-2 FIR: one shared pre-add/multiply/accumulate
// datapath serves NUM_CH interleaved channels, with valid/ready on both sides.
module halfband_decim_tdm #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 25,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned K         = 3,
  parameter int unsigned OUT_SHIFT = 3,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned CA_W     = $clog2(K + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic                     coef_we,
  input  logic [CA_W-1:0]          coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [ACC_W-1:0]  y_out
);

  localparam int unsigned TAPS  = 4 * K - 1;
  localparam int unsigned J_W   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned PRE_W = DATA_W + 1;
  localparam int unsigned PRD_W = PRE_W + COEF_W;

  typedef enum logic [1:0] {IDLE, PAIR, CENTER, OUT} state_t;

  state_t                    r_state;
  logic signed [DATA_W-1:0]  r_dly [NUM_CH][TAPS];
  logic [NUM_CH-1:0]         r_phase;
  logic signed [COEF_W-1:0]  r_coef [K+1];
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_prod;
  logic signed [ACC_W-1:0]   r_y;
  logic [CH_W-1:0]           r_ch;
  logic [CH_W-1:0]           r_out_ch;
  logic [J_W-1:0]            r_j;
  logic                      r_last;
  logic                      r_in_ready;
  logic                      r_out_valid;

  logic signed [DATA_W-1:0]  w_a;
  logic signed [DATA_W-1:0]  w_b;
  logic signed [COEF_W-1:0]  w_c;
  logic signed [PRE_W-1:0]   w_pre;
  logic signed [PRD_W-1:0]   w_prd;
  logic signed [ACC_W-1:0]   w_prd_ext;
  logic signed [ACC_W-1:0]   w_sum;

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign y_out     = r_y;

  // Tap-pair / centre-tap selection for the latched channel, then pre-add and multiply
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == CH_W'(c)) begin
        if (r_state == CENTER) begin
          w_a = r_dly[c][2*K-1];
          w_c = r_coef[K];
        end else begin
          for (int j = 0; j < K; j++) begin
            if (r_j == J_W'(j)) begin
              w_a = r_dly[c][2*j];
              w_b = r_dly[c][TAPS-1-2*j];
              w_c = r_coef[j];
            end
          end
        end
      end
    end
    w_pre     = PRE_W'(w_a) + PRE_W'(w_b);
    w_prd     = PRD_W'(w_pre) * PRD_W'(w_c);
    w_prd_ext = ACC_W'(w_prd);
    w_sum     = r_acc + r_prod;
  end

  // Control FSM; the product register splits multiply from accumulate, so CENTER
  // spends a second cycle draining the last product before the result is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          r_dly[c][t] <= '0;
        end
      end
      for (int i = 0; i <= K; i++) begin
        r_coef[i] <= '0;
      end
      r_phase     <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_y         <= '0;
      r_ch        <= '0;
      r_out_ch    <= '0;
      r_j         <= '0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (coef_we) begin
            for (int i = 0; i <= K; i++) begin
              if (coef_addr == CA_W'(i)) begin
                r_coef[i] <= coef_data;
              end
            end
          end
          if (in_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (in_ch == CH_W'(c)) begin
                for (int t = TAPS - 1; t > 0; t--) begin
                  r_dly[c][t] <= r_dly[c][t-1];
                end
                r_dly[c][0] <= x_in;
                r_phase[c]  <= ~r_phase[c];
                if (r_phase[c]) begin
                  r_ch       <= CH_W'(c);
                  r_acc      <= '0;
                  r_prod     <= '0;
                  r_j        <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= PAIR;
                end
              end
            end
          end
        end
        PAIR: begin
          r_prod <= w_prd_ext;
          r_acc  <= w_sum;
          r_j    <= r_j + J_W'(1);
          r_last <= 1'b0;
          if (r_j == J_W'(K - 1)) begin
            r_state <= CENTER;
          end
        end
        CENTER: begin
          if (!r_last) begin
            r_prod <= w_prd_ext;
            r_acc  <= w_sum;
            r_last <= 1'b1;
          end else begin
            r_y         <= w_sum >>> OUT_SHIFT;
            r_out_ch    <= r_ch;
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
